// File: rtl/bcm_frame_loader.sv
// Ping-pong frame loader: streams one frame of brightness bytes into the bank the BCM
// reader is not scanning, and swaps banks only on the reader's wrap. Optional macro: BCM_GAMMA_EN.
module bcm_frame_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              rd_wrap,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_bank,
  output logic              frame_done,
  output logic              err_short
);

  typedef enum logic {
    FILL      = 1'b0,
    WAIT_SWAP = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic              rd_bank_reg, rd_bank_next;
  logic              frame_done_reg, frame_done_next;
  logic              err_short_reg, err_short_next;
  logic              wr_en_reg;
  logic [ADDR_W:0]   wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic [DATA_W-1:0] data_in;
  logic              accept;

`ifdef BCM_GAMMA_EN
  // g = (d*d + 255) >> 8 with a 16-bit product; maps 0->0 and 255->255 exactly.
  assign data_in = DATA_W'((16'(in_data) * 16'(in_data) + 16'd255) >> 8);
`else
  assign data_in = in_data;
`endif

  assign in_ready = (state_reg == FILL);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    rd_bank_next    = rd_bank_reg;
    frame_done_next = 1'b0;
    err_short_next  = 1'b0;
    case (state_reg)
      FILL: begin
        // rd_wrap is deliberately ignored here so the reader never sees a partial frame.
        if (accept) begin
          if (ptr_reg == PTR_MAX) begin
            state_next = WAIT_SWAP;
            ptr_next   = '0;
          end else if (in_last) begin
            ptr_next       = '0;
            err_short_next = 1'b1;
          end else begin
            ptr_next = ptr_reg + 1'b1;
          end
        end
      end
      WAIT_SWAP: begin
        if (rd_wrap) begin
          rd_bank_next    = ~rd_bank_reg;
          state_next      = FILL;
          frame_done_next = 1'b1;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= FILL;
      ptr_reg        <= '0;
      rd_bank_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      err_short_reg  <= 1'b0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      rd_bank_reg    <= rd_bank_next;
      frame_done_reg <= frame_done_next;
      err_short_reg  <= err_short_next;
      wr_en_reg      <= accept;
      // Address and data hold between writes; only wr_en qualifies them.
      if (accept) begin
        wr_addr_reg <= {~rd_bank_reg, ptr_reg};
        wr_data_reg <= data_in;
      end
    end
  end

  assign wr_en      = wr_en_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign rd_bank    = rd_bank_reg;
  assign frame_done = frame_done_reg;
  assign err_short  = err_short_reg;

endmodule

// File: tb/tb_bcm_frame_loader.sv
// Directed + randomized bench for bcm_frame_loader with a frame-level reference model.
// Honours BCM_GAMMA_EN the same way the design does.
module tb_bcm_frame_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       rd_wrap = 1'b0;
  logic       wr_en;
  logic [8:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_bank;
  logic       frame_done;
  logic       err_short;

  int checks = 0;
  int failures = 0;

  // Reference model: which bank the reader owns, how far into the frame we are,
  // whether a full frame is waiting for the reader, and the last written word.
  bit       m_bank;
  int       m_pos;
  bit       m_full;
  bit [8:0] m_addr;
  bit [7:0] m_data;

  bcm_frame_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .rd_wrap(rd_wrap), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_bank(rd_bank), .frame_done(frame_done), .err_short(err_short)
  );

  always #5 clk = ~clk;

  function automatic int gamma_ref(int d);
`ifdef BCM_GAMMA_EN
    return (d * d + 255) / 256;
`else
    return d;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bank = 1'b0;
    m_pos  = 0;
    m_full = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // One clock: drive inputs at negedge, check in_ready, then check registered outputs after the edge.
  task automatic step(input bit valid, input bit [7:0] data, input bit last, input bit wrap);
    bit acc, exp_short, exp_done;
    @(negedge clk);
    in_valid = valid;
    in_data  = data;
    in_last  = last;
    rd_wrap  = wrap;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_full));
    acc       = valid && !m_full;
    exp_short = acc && last && (m_pos != 255);
    exp_done  = m_full && wrap;
    if (acc) begin
      m_addr = {~m_bank, 8'(m_pos)};
      m_data = 8'(gamma_ref(int'(data)));
      if (m_pos == 255) begin
        m_full = 1'b1;
        m_pos  = 0;
      end else if (last) m_pos = 0;
      else m_pos++;
    end else if (exp_done) begin
      m_bank = ~m_bank;
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("wr_en", 32'(wr_en), 32'(acc));
    chk("wr_addr", 32'(wr_addr), 32'(m_addr));
    chk("wr_data", 32'(wr_data), 32'(m_data));
    chk("err_short", 32'(err_short), 32'(exp_short));
    chk("frame_done", 32'(frame_done), 32'(exp_done));
    chk("rd_bank", 32'(rd_bank), 32'(m_bank));
  endtask

  // Stream n bytes with last on the final one; optional random idle gaps and stray rd_wrap.
  task automatic send_frame(input int n, input bit index_data, input bit gaps, input bit wrap_on_last);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0)
        step(1'b0, 8'($urandom), 1'b0, 1'($urandom));
      step(1'b1, index_data ? 8'(i) : 8'($urandom), (i == n - 1),
           (i == n - 1) ? wrap_on_last : (gaps ? 1'($urandom) : 1'b0));
    end
  endtask

  initial begin
    bit [7:0] gin [4];
    bit [7:0] gout [4];
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_rd_bank", 32'(rd_bank), 32'd0);
    $display("txn reset: released");

    send_frame(256, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    $display("txn frame0: 256 index bytes to bank 1, loader waiting");

    step(1'b0, 8'd0, 1'b0, 1'b1);
    chk("swap_bank", 32'(rd_bank), 32'd1);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    chk("done_once", 32'(frame_done), 32'd0);
    $display("txn swap: rd_bank=%0d", rd_bank);

    send_frame(256, 1'b0, 1'b1, 1'b1);
    chk("collision_nowrap", 32'(rd_bank), 32'd1);
    for (int i = 0; i < 50; i++) step(1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    chk("collision_swap", 32'(rd_bank), 32'd0);
    $display("txn frame1: random bytes to bank 0, collision wrap ignored, swapped later");

    send_frame(10, 1'b0, 1'b0, 1'b0);
    chk("short_pulse", 32'(err_short), 32'd1);
    step(1'b1, 8'h5a, 1'b0, 1'b0);
    chk("short_restart_addr", 32'(wr_addr), 32'h100);
    chk("short_bank", 32'(rd_bank), 32'd0);
    $display("txn short: 10-byte frame aborted, restart at entry 0");

    for (int i = 0; i < 30; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 32'(wr_en), 32'd0);
    chk("arst_wr_addr", 32'(wr_addr), 32'd0);
    chk("arst_wr_data", 32'(wr_data), 32'd0);
    chk("arst_rd_bank", 32'(rd_bank), 32'd0);
    chk("arst_done", 32'(frame_done), 32'd0);
    chk("arst_short", 32'(err_short), 32'd0);
    in_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_ready", 32'(in_ready), 32'd1);
    $display("txn reset: mid-frame reset discarded partial frame");

    gin = '{8'd0, 8'd1, 8'd128, 8'd255};
`ifdef BCM_GAMMA_EN
    gout = '{8'd0, 8'd1, 8'd64, 8'd255};
`else
    gout = '{8'd0, 8'd1, 8'd128, 8'd255};
`endif
    for (int i = 0; i < 4; i++) begin
      step(1'b1, gin[i], 1'b0, 1'b0);
      chk("gamma_point", 32'(wr_data), 32'(gout[i]));
    end
    send_frame(252, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    chk("final_bank", 32'(rd_bank), 32'd1);
    $display("txn gamma: reference points written, frame completed and swapped");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcm_frame_loader.md
Name: bcm_frame_loader

Overview:
- Write-side counterpart of the BCM address pointer. Accepts a stream of 8-bit brightness bytes over a valid/ready handshake and writes one full frame (2^ADDR_W entries) into a ping-pong brightness RAM.
- The BCM reader scans the active bank. The loader fills the inactive bank.
- The bank swap occurs only when the reader's address wraps, so the reader never sees a torn frame.

Parameters:
- ADDR_W, 8, frame address width; frame depth = 2^ADDR_W entries.
- DATA_W, 8, brightness word width. Must be 8 when BCM_GAMMA_EN is defined.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input byte valid.
- in_data  input  DATA_W  brightness byte.
- in_last  input  1  marks final byte of a frame.
- in_ready  output  1  loader can accept a byte.
- rd_wrap  input  1  single-cycle pulse from reader when its address wraps from max to 0.
- wr_en  output  1  RAM write strobe.
- wr_addr  output  ADDR_W+1  RAM write address; MSB = bank, LSBs = entry.
- wr_data  output  DATA_W  RAM write data.
- rd_bank  output  1  bank the reader must use; MSB of the reader's RAM address.
- frame_done  output  1  one-cycle pulse after a bank swap.
- err_short  output  1  one-cycle pulse when a frame is aborted by an early in_last.

Behaviour:
- Reset values (asynchronous, applied while rst_n = 0):
  - state = FILL, ptr = 0, rd_bank = 0.
  - wr_en = 0, wr_addr = 0, wr_data = 0.
  - frame_done = 0, err_short = 0.
- Write bank is always ~rd_bank.
- Accept = in_valid & in_ready.
- Write path (1-cycle registered latency):
  - On the edge where accept is true: wr_en <= 1, wr_addr <= {~rd_bank, ptr}, wr_data <= in_data (after gamma if enabled).
  - On any other edge: wr_en <= 0; wr_addr and wr_data hold their values.
- State FILL:
  - in_ready = 1.
  - On accept with ptr < 2^ADDR_W-1 and in_last = 0: ptr <= ptr+1.
  - On accept with ptr < 2^ADDR_W-1 and in_last = 1:
    - The byte is still written.
    - err_short pulses on the next cycle.
    - ptr <= 0 and state stays FILL; the partial frame is discarded and overwritten by the next frame.
  - On accept with ptr = 2^ADDR_W-1: state <= WAIT_SWAP and ptr <= 0, regardless of in_last (in_last ignored at this entry).
  - rd_wrap is ignored in FILL.
- State WAIT_SWAP:
  - in_ready = 0.
  - On rd_wrap = 1: rd_bank <= ~rd_bank, state <= FILL, and frame_done pulses high for the cycle after the swap edge.
  - Otherwise hold.
- Ordering of last write vs. swap: the registered write of the final entry lands on the first edge in WAIT_SWAP. The earliest possible swap is that same edge, so the write always completes before the bank flips.
- Simultaneous events:
  - Final-entry accept and rd_wrap on the same edge: state is still FILL, so the wrap is ignored and the swap waits for the next rd_wrap.
  - err_short and frame_done can never be high in the same cycle.
- in_ready is a combinational function of state only. It does not depend on in_valid.
- Reset mid-frame discards the partial frame and returns rd_bank to 0.

Optional Feature:
- Macro BCM_GAMMA_EN.
- Defined: the written data is the gamma-corrected value g = (d*d + 255) >> 8, computed combinationally ahead of the wr_data register with a 16-bit product. Reference points: 0→0, 1→1, 128→64, 255→255. Latency is unchanged.
- Undefined: wr_data = in_data unmodified.

Test Plan:
- Reset check: assert rst_n = 0 mid-stream. Outputs go to 0 immediately and in_ready = 1 after release.
- Full frame fill: stream 256 bytes (value = index), in_last on byte 255, rd_wrap held 0.
  - wr_en pulses 256 times with wr_addr = 256+i and wr_data = i.
  - in_ready drops the cycle after byte 255 and stays 0.
- Swap: from WAIT_SWAP, pulse rd_wrap.
  - rd_bank goes 0→1 and frame_done = 1 for exactly one cycle.
  - The next frame writes to addresses 0..255.
- Short frame: in_last on byte 9.
  - err_short pulses once, the next byte is written to entry 0, and rd_bank is unchanged.
- Collision: rd_wrap on the same edge as the byte-255 accept. No swap occurs; the swap happens on the following rd_wrap pulse 50 cycles later.
- Gamma (BCM_GAMMA_EN defined): inputs 0, 1, 128, 255 produce wr_data 0, 1, 64, 255. Without the macro, the same inputs are written unmodified.
